fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined MIPS core. Owns the PC, drives the
//  ProgramMemory address, and loads the IF/ID pipeline register that feeds decode.
//  Accepts stall/flush from the hazard unit and PC redirects from branch/jump/jr
//  resolution. Halts cleanly when the PC leaves the program image.
// PARAMETERS
//  RESET_PC      32'h0040_0000  first fetch address after reset, word aligned
//  PC_INCREMENT  4              sequential PC step, in bytes
//  MEMORY_DEPTH  64             program size in words; END_PC = RESET_PC + 4*MEMORY_DEPTH
// PORTS
//  clk             in   1   core clock, rising edge
//  reset           in   1   synchronous, active-high
//  stall           in   1   hold the PC and IF/ID contents
//  flush           in   1   load a bubble into IF/ID
//  redirect_valid  in   1   take redirect_pc as the next PC
//  redirect_pc     in   32  branch/jump/jr target
//  imem_instr      in   32  ProgramMemory data for imem_addr, combinational
//  imem_addr       out  32  = pc, combinational
//  pc_value        out  32  current PC register
//  if_id_pc_plus4  out  32  registered PC+PC_INCREMENT of the captured instruction
//  if_id_instr     out  32  registered instruction
//  if_id_valid     out  1   registered; 0 = bubble
//  halted          out  1   1 while state == HALT
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=RUN, halted=0, if_id_{pc_plus4,instr}=0, if_id_valid=0.
//  - Bubble: instr=32'h0 (sll nop), pc_plus4=0, valid=0.
//  - Latency: the instruction at pc appears on if_id_* one edge later.
//  - Priority per edge: reset > redirect_valid > stall > flush > normal.
//  - redirect_valid (any state, overrides stall):
//    pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble.
//    Masked target in [RESET_PC, END_PC) -> RUN; otherwise -> HALT.
//  - stall (no redirect): pc and IF/ID hold. stall+flush: pc holds, IF/ID <= bubble.
//  - flush alone: IF/ID <= bubble; pc advances as in normal operation.
//  - Normal RUN: IF/ID <= {pc+PC_INCREMENT, imem_instr, 1}; pc <= pc+PC_INCREMENT.
//    If pc+PC_INCREMENT == END_PC, state <= HALT on the same edge.
//    Last instruction is still captured valid.
//  - HALT: pc holds; IF/ID <= bubble each edge; halted=1 (combinational from state).
//    Exit only via redirect or reset.
//  - Adds are 32-bit modulo.
//  - RESET_PC must be word aligned; there is no alignment check on it.
//  - States: RUN -> HALT (end of image or out-of-range redirect).
//    HALT -> RUN (in-range redirect). Any state -> RUN on reset.
// TESTING
//  1 reset, imem returns 0x20080005/0x20090007/0x01095020, 3 edges
//    -> pc 0x400004,0x400008,0x40000C; if_id_instr follows 1 edge late;
//    if_id_valid=1 from edge 1; if_id_pc_plus4 0x400004..0x40000C.
//  2 stall=1 for 2 edges at pc 0x400008 -> pc, if_id_* unchanged; release resumes at 0x400008.
//  3 stall=1 with redirect_valid=1, redirect_pc=0x00400022
//    -> pc=0x00400020, if_id_valid=0, if_id_instr=0.
//  4 MEMORY_DEPTH=4, run from reset -> after 4th edge pc=0x00400010, halted=1;
//    0x40000C instr captured valid; further edges give bubbles;
//    redirect 0x400004 -> halted=0, fetch resumes at 0x400004.
//  5 redirect_pc=0x00000100 -> next edge pc=0x100, halted=1, if_id_valid=0.
//  6 reset=1 during stall+HALT -> next edge pc=0x400000, halted=0, all if_id_*=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, ProgramMemory port and IF/ID outputs.
// master = fetch stage, slave = surrounding core (or bench).
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_instr;
   logic [31:0] imem_addr;
   logic [31:0] pc_value;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        halted;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, imem_instr,
      output imem_addr, pc_value, if_id_pc_plus4, if_id_instr,
             if_id_valid, halted
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, imem_instr,
      input  imem_addr, pc_value, if_id_pc_plus4, if_id_instr,
             if_id_valid, halted
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads ProgramMemory, loads IF/ID.
// Halts when the PC leaves [RESET_PC, END_PC); exits on in-range redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0040_0000,
   parameter logic [31:0] PC_INCREMENT = 32'd4,
   parameter int unsigned MEMORY_DEPTH = 64
) (
   input logic           clk,
   input logic           reset,
   fetch_stage_if.master bus
);

   localparam logic [31:0] END_PC = RESET_PC + (32'(MEMORY_DEPTH) << 2);

   typedef enum logic {RUN, HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] p4_q, p4_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_next;
   logic [31:0] tgt;
   logic        tgt_ok;

   always_comb begin
      pc_next = pc_q + PC_INCREMENT;
      tgt     = bus.redirect_pc & ~32'h3;
      tgt_ok  = (tgt >= RESET_PC) && (tgt < END_PC);
      state_d = state_q;
      pc_d    = pc_q;
      p4_d    = p4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      // redirect > stall > flush > normal; HALT behaves as a held PC
      if (bus.redirect_valid) begin
         pc_d    = tgt;
         state_d = tgt_ok ? RUN : HALT;
         p4_d    = '0;
         instr_d = '0;
         valid_d = 1'b0;
      end else if (bus.stall) begin
         if (bus.flush) begin
            p4_d    = '0;
            instr_d = '0;
            valid_d = 1'b0;
         end
      end else if (state_q == HALT) begin
         p4_d    = '0;
         instr_d = '0;
         valid_d = 1'b0;
      end else begin
         pc_d    = pc_next;
         p4_d    = pc_next;
         instr_d = bus.imem_instr;
         valid_d = 1'b1;
         if (pc_next == END_PC) state_d = HALT;
         if (bus.flush) begin
            p4_d    = '0;
            instr_d = '0;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         p4_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         p4_q    <= p4_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign bus.imem_addr      = pc_q;
   assign bus.pc_value       = pc_q;
   assign bus.if_id_pc_plus4 = p4_q;
   assign bus.if_id_instr    = instr_q;
   assign bus.if_id_valid    = valid_q;
   assign bus.halted         = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed sequence then random traffic,
// expected state from a program-image reference model.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] END_PC = RST_PC + 32'(4 * DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] p4;
      logic [31:0] ins;
      logic        v;
      logic        h;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   logic [31:0] prog [DEPTH];

   logic [31:0] m_pc, m_p4, m_ins;
   logic        m_v, m_h;

   fetch_stage_if bus();

   fetch_stage #(
      .RESET_PC    (RST_PC),
      .PC_INCREMENT(32'd4),
      .MEMORY_DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      int unsigned idx;
      if (a >= RST_PC && a < END_PC) begin
         idx = (a - RST_PC) / 4;
         return prog[idx];
      end
      return {a[15:0], 16'hdead};
   endfunction

   assign bus.imem_instr = mem_word(bus.imem_addr);

   // Reference: which word the PC sits on decides everything
   task automatic model_step(input bit r, input bit st, input bit fl,
                             input bit rv, input logic [31:0] rpc);
      logic [31:0] t;
      if (r) begin
         m_pc = RST_PC; m_h = 0; m_p4 = 0; m_ins = 0; m_v = 0;
      end else if (rv) begin
         t = rpc & ~32'h3;
         m_pc = t;
         m_h = !(t >= RST_PC && t < END_PC);
         m_p4 = 0; m_ins = 0; m_v = 0;
      end else if (st) begin
         if (fl) begin m_p4 = 0; m_ins = 0; m_v = 0; end
      end else if (m_h) begin
         m_p4 = 0; m_ins = 0; m_v = 0;
      end else begin
         m_ins = mem_word(m_pc);
         m_pc  = m_pc + 4;
         m_p4  = m_pc;
         m_v   = 1;
         if ((m_pc - RST_PC) / 4 == DEPTH) m_h = 1;
         if (fl) begin m_p4 = 0; m_ins = 0; m_v = 0; end
      end
      sb.push_back('{m_pc, m_p4, m_ins, m_v, m_h});
   endtask

   task automatic cyc(input bit r, input bit st, input bit fl,
                      input bit rv, input logic [31:0] rpc);
      @(negedge clk);
      reset              = r;
      bus.stall          = st;
      bus.flush          = fl;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      model_step(r, st, fl, rv, rpc);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("pc_value", bus.pc_value, e.pc);
         chk("imem_addr", bus.imem_addr, e.pc);
         chk("if_id_pc_plus4", bus.if_id_pc_plus4, e.p4);
         chk("if_id_instr", bus.if_id_instr, e.ins);
         chk("if_id_valid", 32'(bus.if_id_valid), 32'(e.v));
         chk("halted", 32'(bus.halted), 32'(e.h));
      end
   end

   task automatic after_edge;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [31:0] rpc;
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0007;
      prog[2] = 32'h0109_5020;
      prog[3] = 32'h3c01_abcd;
      reset = 1; bus.stall = 0; bus.flush = 0;
      bus.redirect_valid = 0; bus.redirect_pc = 0;

      cyc(1, 0, 0, 0, 0);
      after_edge();
      chk("reset_pc", bus.pc_value, 32'h0040_0000);
      chk("reset_valid", 32'(bus.if_id_valid), 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      after_edge();
      chk("seq_pc2", bus.pc_value, 32'h0040_0008);
      chk("seq_instr2", bus.if_id_instr, 32'h2009_0007);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      after_edge();
      chk("stall_pc", bus.pc_value, 32'h0040_0008);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      after_edge();
      chk("end_pc", bus.pc_value, 32'h0040_0010);
      chk("end_halted", 32'(bus.halted), 1);
      chk("last_instr", bus.if_id_instr, 32'h3c01_abcd);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 32'h0040_0004);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 32'h0040_0022);
      after_edge();
      chk("redir_stall_pc", bus.pc_value, 32'h0040_0020);
      cyc(0, 0, 0, 1, 32'h0040_0000);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 0, 1, 32'h0000_0100);
      after_edge();
      chk("oor_pc", bus.pc_value, 32'h0000_0100);
      chk("oor_halted", 32'(bus.halted), 1);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      after_edge();
      chk("rst_halt_pc", bus.pc_value, 32'h0040_0000);
      chk("rst_halt_h", 32'(bus.halted), 0);

      for (int i = 0; i < 600; i++) begin
         bit r, st, fl, rv;
         r  = ($urandom_range(0, 49) == 0);
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 5) == 0);
         rv = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) != 0)
            rpc = RST_PC + 32'($urandom_range(0, 4 * DEPTH + 3));
         else
            rpc = $urandom;
         cyc(r, st, fl, rv, rpc);
      end

      cyc(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #3;
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
